// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared types and constants for the traffic-light observer.
//   phase_t        : lamp phase as tracked by the checker (SYNC/RED/GREEN/YELLOW)
//   DEF_*_CYCLES   : default enabled-cycle dwell of each phase
//   L_*            : one-hot lamp vectors, bit order {red, yellow, green}
//   lamp_to_phase  : decodes a lamp vector; any non-one-hot code maps to PH_SYNC
//   next_phase     : the only legal successor of each lamp phase
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_t;

  localparam int DEF_RED_CYCLES    = 32;
  localparam int DEF_GREEN_CYCLES  = 20;
  localparam int DEF_YELLOW_CYCLES = 7;

  localparam int DWELL_W = 8;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  function automatic phase_t lamp_to_phase(input logic [2:0] lamp);
    case (lamp)
      L_RED:    return PH_RED;
      L_GREEN:  return PH_GREEN;
      L_YELLOW: return PH_YELLOW;
      default:  return PH_SYNC;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/tl_dwell_counter.sv
// tl_dwell_counter
// Counts enabled cycles spent in the current lamp phase, saturating at all-ones.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : force count to 0 (highest priority)
//   load1      : force count to 1 (first enabled cycle of a new phase)
//   inc        : add one, holding at all-ones
//   count      : current dwell count
module tl_dwell_counter
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load1,
  input  logic               inc,
  output logic [DWELL_W-1:0] count
);

  logic [DWELL_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = DWELL_W'(1);
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + DWELL_W'(1);
    end
  end

  // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_light_checker.sv
// traffic_light_checker
// Passive observer of a red/green/yellow lamp controller. Tracks the lamp phase,
// flags non-one-hot lamp codes, out-of-order transitions and wrong phase lengths,
// and counts completed RED->GREEN->YELLOW->RED cycles.
//   clk, reset         : clock, asynchronous active-high reset
//   enable             : controller enable; dwell only advances while high
//   red, yellow, green : sampled controller lamps
//   cur_phase          : phase seen at the previous edge (0=SYNC,1=RED,2=GREEN,3=YELLOW)
//   err_onehot         : one-cycle pulse, lamp vector not one-hot
//   err_seq            : one-cycle pulse, illegal phase order
//   err_dwell          : one-cycle pulse, phase too short or too long
//   err_sticky         : OR of all error pulses since reset
//   cycle_count        : completed legal cycles, saturating
module traffic_light_checker
  import traffic_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic [1:0]       cur_phase,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cycle_count
);

  // The dwell counter saturates at 255, so expected+1 must stay representable.
  if (RED_CYCLES < 1 || RED_CYCLES > 254 ||
      GREEN_CYCLES < 1 || GREEN_CYCLES > 254 ||
      YELLOW_CYCLES < 1 || YELLOW_CYCLES > 254) begin : g_bad_dwell_param
    $error("traffic_light_checker: phase durations must be in 1..254");
  end

  phase_t             phase_q, phase_d;
  logic               partial_q, partial_d;   // phase adopted from SYNC, never dwell-checked
  logic               overrun_q, overrun_d;   // overrun already reported in this phase
  logic               cyc_ok_q, cyc_ok_d;     // current cycle began with a legal YELLOW->RED
  logic               err_onehot_q, err_onehot_d;
  logic               err_seq_q, err_seq_d;
  logic               err_dwell_q, err_dwell_d;
  logic               err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;

  logic               dw_clr, dw_load1, dw_inc;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [2:0]         lamp;
  phase_t             lamp_phase;
  logic               lamp_ok, same_phase, trans, legal_trans, illegal_trans, overrun_hit;
  logic [DWELL_W-1:0] exp_dwell;

  function automatic logic [DWELL_W-1:0] dwell_for(input phase_t ph);
    case (ph)
      PH_RED:    return DWELL_W'(RED_CYCLES);
      PH_GREEN:  return DWELL_W'(GREEN_CYCLES);
      PH_YELLOW: return DWELL_W'(YELLOW_CYCLES);
      default:   return '0;
    endcase
  endfunction

  assign lamp          = {red, yellow, green};
  assign lamp_phase    = lamp_to_phase(lamp);
  assign lamp_ok       = (lamp_phase != PH_SYNC);
  assign exp_dwell     = dwell_for(phase_q);
  assign same_phase    = lamp_ok && (lamp_phase == phase_q);
  assign trans         = lamp_ok && (phase_q != PH_SYNC) && (lamp_phase != phase_q);
  assign legal_trans   = trans && (lamp_phase == next_phase(phase_q));
  assign illegal_trans = trans && !legal_trans;
  // The counter moves from expected to expected+1 on this edge.
  assign overrun_hit   = same_phase && enable && !partial_q && !overrun_q &&
                         (dwell_cnt == exp_dwell);

  tl_dwell_counter u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (dw_clr),
    .load1 (dw_load1),
    .inc   (dw_inc),
    .count (dwell_cnt)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PH_SYNC;
      partial_q     <= 1'b0;
      overrun_q     <= 1'b0;
      cyc_ok_q      <= 1'b0;
      err_onehot_q  <= 1'b0;
      err_seq_q     <= 1'b0;
      err_dwell_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      phase_q       <= phase_d;
      partial_q     <= partial_d;
      overrun_q     <= overrun_d;
      cyc_ok_q      <= cyc_ok_d;
      err_onehot_q  <= err_onehot_d;
      err_seq_q     <= err_seq_d;
      err_dwell_q   <= err_dwell_d;
      err_sticky_q  <= err_sticky_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next-state: phase tracking and dwell counter control.
  always_comb begin
    phase_d   = phase_q;
    partial_d = partial_q;
    overrun_d = overrun_q;
    cyc_ok_d  = cyc_ok_q;
    dw_clr    = 1'b0;
    dw_load1  = 1'b0;
    dw_inc    = 1'b0;
    if (!lamp_ok) begin
      phase_d   = PH_SYNC;
      partial_d = 1'b0;
      overrun_d = 1'b0;
      cyc_ok_d  = 1'b0;
      dw_clr    = 1'b1;
    end else if (phase_q == PH_SYNC) begin
      phase_d   = lamp_phase;
      partial_d = 1'b1;
      overrun_d = 1'b0;
      cyc_ok_d  = 1'b0;
      dw_load1  = enable;
      dw_clr    = !enable;
    end else if (same_phase) begin
      dw_inc = enable;
      if (overrun_hit) overrun_d = 1'b1;
    end else begin
      phase_d   = lamp_phase;
      partial_d = 1'b0;
      overrun_d = 1'b0;
      dw_load1  = enable;
      dw_clr    = !enable;
      if (illegal_trans)             cyc_ok_d = 1'b0;
      else if (phase_q == PH_YELLOW) cyc_ok_d = 1'b1;
    end
  end

  // Outputs: error pulses and cycle counter, registered by the state process.
  always_comb begin
    err_onehot_d  = !lamp_ok;
    err_seq_d     = illegal_trans;
    err_dwell_d   = overrun_hit ||
                    (legal_trans && !partial_q && !overrun_q && (dwell_cnt != exp_dwell));
    err_sticky_d  = err_sticky_q | err_onehot_d | err_seq_d | err_dwell_d;
    cycle_count_d = cycle_count_q;
    if (legal_trans && (phase_q == PH_YELLOW) && cyc_ok_q && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  assign cur_phase   = phase_q;
  assign err_onehot  = err_onehot_q;
  assign err_seq     = err_seq_q;
  assign err_dwell   = err_dwell_q;
  assign err_sticky  = err_sticky_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// tb_traffic_light_checker
// Table-driven directed sequences, a nominal controller run and randomized lamp
// traffic, all compared against a segment-based reference model of the checker.
module tb_traffic_light_checker;
  import traffic_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        red, yellow, green;
  logic [1:0]  cur_phase;
  logic        err_onehot, err_seq, err_dwell, err_sticky;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_checker dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .cur_phase   (cur_phase),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq),
    .err_dwell   (err_dwell),
    .err_sticky  (err_sticky),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the current lamp segment: its phase (1=R,2=G,3=Y), how many enabled
  // cycles it has lasted (unbounded), whether it was picked up from SYNC, and the
  // length of the legal chain that started with a legally entered RED.
  int m_phase, m_run, m_chain, m_cc;
  bit m_from_sync, m_oh, m_sq, m_dw, m_st;

  function automatic int exp_len(input int ph);
    case (ph)
      1:       return 32;
      2:       return 20;
      3:       return 7;
      default: return 0;
    endcase
  endfunction

  function automatic int lamp_ph(input logic [2:0] l);
    if (l == 3'b100) return 1;
    if (l == 3'b001) return 2;
    if (l == 3'b010) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_chain = 0; m_cc = 0;
    m_from_sync = 0; m_oh = 0; m_sq = 0; m_dw = 0; m_st = 0;
  endtask

  task automatic model_step(input logic [2:0] l, input bit en);
    int ph;
    ph = lamp_ph(l);
    m_oh = 0; m_sq = 0; m_dw = 0;
    if (ph == 0) begin
      m_oh = 1; m_phase = 0; m_run = 0; m_chain = 0;
    end else if (m_phase == 0) begin
      m_phase = ph; m_run = int'(en); m_from_sync = 1; m_chain = 0;
    end else if (ph == m_phase) begin
      if (en) begin
        m_run++;
        if (!m_from_sync && m_run == exp_len(ph) + 1) m_dw = 1;
      end
    end else begin
      if (ph == (m_phase % 3) + 1) begin
        // Longer-than-expected segments were already reported as overrun.
        if (!m_from_sync && m_run < exp_len(m_phase)) m_dw = 1;
        if (ph == 1) begin
          if (m_chain == 3 && m_cc < 65535) m_cc++;
          m_chain = 1;
        end else if (m_chain > 0) begin
          m_chain++;
        end
      end else begin
        m_sq = 1; m_chain = 0;
      end
      m_phase = ph; m_run = int'(en); m_from_sync = 0;
    end
    if (m_oh || m_sq || m_dw) m_st = 1;
  endtask

  task automatic compare_model();
    check("model_phase",  32'(cur_phase),   32'(m_phase));
    check("model_onehot", 32'(err_onehot),  32'(m_oh));
    check("model_seq",    32'(err_seq),     32'(m_sq));
    check("model_dwell",  32'(err_dwell),   32'(m_dw));
    check("model_sticky", 32'(err_sticky),  32'(m_st));
    check("model_count",  32'(cycle_count), 32'(m_cc));
  endtask

  // One sampled cycle: drive, clock, advance the model, compare just after the edge.
  task automatic apply(input logic [2:0] l, input logic en);
    red = l[2]; yellow = l[1]; green = l[0]; enable = en;
    @(posedge clk);
    model_step(l, en);
    #1;
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},  32'(cur_phase),   0);
    check({tag, "_onehot"}, 32'(err_onehot),  0);
    check({tag, "_seq"},    32'(err_seq),     0);
    check({tag, "_dwell"},  32'(err_dwell),   0);
    check({tag, "_sticky"}, 32'(err_sticky),  0);
    check({tag, "_count"},  32'(cycle_count), 0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0] lamp;
    logic       en;
    int         n;     // cycles to hold this lamp/enable
    int         ph;    // expected after the last cycle
    logic       oh, sq, dw, st;
    int         cc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] lamp, input logic en, input int n, input int ph,
                              input logic oh, input logic sq, input logic dw, input logic st,
                              input int cc);
    vec_t v;
    v.lamp = lamp; v.en = en; v.n = n; v.ph = ph;
    v.oh = oh; v.sq = sq; v.dw = dw; v.st = st; v.cc = cc;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; red = 1'b0; yellow = 1'b0; green = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    //   lamp      en    n   ph oh sq dw st cc
    add(L_RED,    1'b1,  3, 1, 0, 0, 0, 0, 0);  // partial first red
    add(L_GREEN,  1'b1, 20, 2, 0, 0, 0, 0, 0);
    add(L_YELLOW, 1'b1,  7, 3, 0, 0, 0, 0, 0);
    add(L_RED,    1'b1,  1, 1, 0, 0, 0, 0, 0);  // first full red, not counted
    add(L_RED,    1'b1, 10, 1, 0, 0, 0, 0, 0);
    add(L_RED,    1'b0,  5, 1, 0, 0, 0, 0, 0);  // frozen dwell
    add(L_RED,    1'b1, 21, 1, 0, 0, 0, 0, 0);  // 32 enabled reds in total
    add(L_GREEN,  1'b1,  1, 2, 0, 0, 0, 0, 0);  // phase 1->2 one cycle after
    add(L_GREEN,  1'b1, 18, 2, 0, 0, 0, 0, 0);  // 19 greens: short
    add(L_YELLOW, 1'b1,  1, 3, 0, 0, 1, 1, 0);  // short-green dwell error
    add(L_YELLOW, 1'b1,  7, 3, 0, 0, 1, 1, 0);  // 8th yellow: overrun
    add(L_YELLOW, 1'b1,  2, 3, 0, 0, 0, 1, 0);  // 10 yellows, no second pulse
    add(L_RED,    1'b1,  1, 1, 0, 0, 0, 1, 1);  // legal order completes a cycle
    add(L_RED,    1'b1, 31, 1, 0, 0, 0, 1, 1);
    add(L_YELLOW, 1'b1,  1, 3, 0, 1, 0, 1, 1);  // illegal RED->YELLOW
    add(L_YELLOW, 1'b1,  6, 3, 0, 0, 0, 1, 1);
    add(L_RED,    1'b1,  1, 1, 0, 0, 0, 1, 1);  // broken cycle not counted
    add(3'b110,   1'b1,  1, 0, 1, 0, 0, 1, 1);
    add(3'b110,   1'b1,  1, 0, 1, 0, 0, 1, 1);  // repeats every bad cycle
    add(L_GREEN,  1'b1,  5, 2, 0, 0, 0, 1, 1);  // resync mid-green

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        apply(vecs[i].lamp, vecs[i].en);
        if (k < vecs[i].n - 1)
          check($sformatf("vec%0d_quiet", i), {29'd0, err_onehot, err_seq, err_dwell}, 0);
      end
      check($sformatf("vec%0d_phase", i),  32'(cur_phase),   32'(vecs[i].ph));
      check($sformatf("vec%0d_onehot", i), 32'(err_onehot),  32'(vecs[i].oh));
      check($sformatf("vec%0d_seq", i),    32'(err_seq),     32'(vecs[i].sq));
      check($sformatf("vec%0d_dwell", i),  32'(err_dwell),   32'(vecs[i].dw));
      check($sformatf("vec%0d_sticky", i), 32'(err_sticky),  32'(vecs[i].st));
      check($sformatf("vec%0d_count", i),  32'(cycle_count), 32'(vecs[i].cc));
    end

    // Reset in the middle of green.
    do_reset("midrst");

    // Nominal controller: red 32, green 20, yellow 7, repeating, for 200 cycles.
    for (int c = 0; c < 200; c++) begin
      int pos;
      pos = c % 59;
      apply(pos < 32 ? L_RED : (pos < 52 ? L_GREEN : L_YELLOW), 1'b1);
    end
    check("nominal_count",  32'(cycle_count), 2);
    check("nominal_sticky", 32'(err_sticky),  0);

    // Randomized segments: mostly legal order with lengths near nominal.
    do_reset("rndrst");
    begin
      int ph;
      ph = 1;
      for (int seg = 0; seg < 200; seg++) begin
        int r, len, sel;
        bit all_en;
        logic [2:0] l;
        r = int'($urandom_range(0, 99));
        all_en = ($urandom_range(0, 1) == 1);
        if (r < 5) begin
          sel = int'($urandom_range(0, 3));
          case (sel)
            0:       l = 3'b000;
            1:       l = 3'b011;
            2:       l = 3'b110;
            default: l = 3'b111;
          endcase
          len = int'($urandom_range(1, 2));
        end else begin
          if (r < 85) ph = (ph % 3) + 1;
          else        ph = int'($urandom_range(1, 3));
          l = (ph == 1) ? L_RED : ((ph == 2) ? L_GREEN : L_YELLOW);
          len = exp_len(ph) + int'($urandom_range(0, 4)) - 2;
        end
        for (int k = 0; k < len; k++)
          apply(l, all_en ? 1'b1 : ($urandom_range(0, 99) < 85));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
